// File: rtl/miriscv_pkg.sv
// Shared miriscv types and constants used by the instruction-side bus bridge.
package miriscv_pkg;

    localparam int XLEN = 32;

    typedef enum logic {
        IBUS_IDLE,
        IBUS_WAIT_GNT
    } ibus_state_e;

    typedef struct packed {
        logic [XLEN-1:0] rdata;
        logic            err;
    } ibus_rsp_t;

endpackage

// File: rtl/miriscv_ibus_rsp_fifo.sv
// Small DEPTH-entry first-word-fall-through response buffer for the ibus bridge.
// The error bit is only stored when MIRISCV_IBUS_ERR_EN is defined.
module miriscv_ibus_rsp_fifo
    import miriscv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         clear,
    input  logic                         push,
    input  ibus_rsp_t                    wdata,
    input  logic                         pop,
    output ibus_rsp_t                    rdata,
    output logic                         empty,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [XLEN-1:0]  data_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             push_ok;
    logic             pop_ok;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CNT_W'(DEPTH));
    assign count   = count_reg;
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (pop_ok) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            if (push_ok && !pop_ok) begin
                count_reg <= count_reg + CNT_W'(1);
            end else if (pop_ok && !push_ok) begin
                count_reg <= count_reg - CNT_W'(1);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk_i) begin
                if (push_ok && (wr_ptr_reg == PTR_W'(gi))) begin
                    data_mem[gi] <= wdata.rdata;
                end
            end
        end
    endgenerate

`ifdef MIRISCV_IBUS_ERR_EN
    logic err_mem [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_err_entry
            always_ff @(posedge clk_i) begin
                if (push_ok && (wr_ptr_reg == PTR_W'(gi))) begin
                    err_mem[gi] <= wdata.err;
                end
            end
        end
    endgenerate

    assign rdata.err = err_mem[rd_ptr_reg];
`else
    logic unused_wdata_err;

    assign unused_wdata_err = wdata.err;
    assign rdata.err        = 1'b0;
`endif

    assign rdata.rdata = data_mem[rd_ptr_reg];

    // The bridge's credit scheme must make this impossible.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(push && full));
        end
    end

endmodule

// File: rtl/miriscv_ibus_bridge.sv
// Fetch-to-bus bridge: req/gnt/rvalid issue, outstanding tracking, flush drop, response buffer.
// Define MIRISCV_IBUS_ERR_EN to carry bus_err_i through to core_err_o.
module miriscv_ibus_bridge
    import miriscv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            core_req_i,
    input  logic [XLEN-1:0] core_addr_i,
    input  logic            core_flush_i,
    input  logic            core_ready_i,
    output logic            core_busy_o,
    output logic            core_rvalid_o,
    output logic [XLEN-1:0] core_rdata_o,
    output logic            core_err_o,
    output logic            bus_req_o,
    output logic [XLEN-1:0] bus_addr_o,
    input  logic            bus_gnt_i,
    input  logic            bus_rvalid_i,
    input  logic [XLEN-1:0] bus_rdata_i,
    input  logic            bus_err_i
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    ibus_state_e      state_reg;
    logic [XLEN-1:0]  addr_q;
    logic [CNT_W-1:0] outstanding_reg;
    logic [CNT_W-1:0] outstanding_next;
    logic [CNT_W-1:0] drop_q;
    logic [CNT_W-1:0] drop_next;
    logic             kill_pending_reg;
    logic             kill_pending_next;

    logic [CNT_W-1:0] rsp_count;
    logic [CNT_W:0]   inflight;
    logic             credit;
    logic             is_idle;
    logic             issue;
    logic             req;
    logic             gnt;
    logic             wait_hit;
    logic             rsp_drop;
    logic             rsp_keep;
    logic             rvalid;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_empty;
    logic             fifo_full;
    ibus_rsp_t        bus_rsp;
    ibus_rsp_t        head_rsp;

    assign inflight = {1'b0, outstanding_reg} + {1'b0, rsp_count};
    assign credit   = (inflight < (CNT_W + 1)'(DEPTH));
    assign is_idle  = (state_reg == IBUS_IDLE);
    assign issue    = is_idle && core_req_i && credit;
    assign req      = !rst_i && (issue || !is_idle);
    assign gnt      = req && bus_gnt_i;
    assign wait_hit = gnt && !is_idle;

    assign bus_req_o   = req;
    assign bus_addr_o  = is_idle ? core_addr_i : addr_q;
    assign core_busy_o = !rst_i && (is_idle ? (core_req_i && !(issue && bus_gnt_i)) : 1'b1);

    // Any response seen during a flush belongs to an old fetch: a request
    // issued in the flush cycle cannot answer in that same cycle.
    assign rsp_drop = bus_rvalid_i && ((drop_q != '0) || core_flush_i);
    assign rsp_keep = bus_rvalid_i && !rsp_drop;

    assign rvalid    = !rst_i && !core_flush_i && (fifo_empty ? rsp_keep : 1'b1);
    assign fifo_pop  = !fifo_empty && rvalid && core_ready_i;
    assign fifo_push = rsp_keep && (!fifo_empty || !core_ready_i);

    assign core_rvalid_o = rvalid;
    assign core_rdata_o  = rst_i ? '0 : (fifo_empty ? bus_rdata_i : head_rsp.rdata);

    assign bus_rsp.rdata = bus_rdata_i;

`ifdef MIRISCV_IBUS_ERR_EN
    logic unused_fifo_full;

    assign unused_fifo_full = fifo_full;
    assign bus_rsp.err      = bus_err_i;
    assign core_err_o       = rvalid && (fifo_empty ? bus_err_i : head_rsp.err);
`else
    logic unused_sig;

    assign unused_sig  = ^{bus_err_i, head_rsp.err, fifo_full};
    assign bus_rsp.err = 1'b0;
    assign core_err_o  = 1'b0;
`endif

    miriscv_ibus_rsp_fifo #(
        .DEPTH (DEPTH)
    ) u_rsp_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clear (core_flush_i),
        .push  (fifo_push),
        .wdata (bus_rsp),
        .pop   (fifo_pop),
        .rdata (head_rsp),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (rsp_count)
    );

    always_comb begin
        outstanding_next = outstanding_reg;
        unique case ({gnt, bus_rvalid_i})
            2'b10:   outstanding_next = outstanding_reg + CNT_W'(1);
            2'b01:   outstanding_next = outstanding_reg - CNT_W'(1);
            default: outstanding_next = outstanding_reg;
        endcase
    end

    // Everything outstanding at flush time is stale, plus the request still
    // waiting for its grant; that one is counted whenever the grant arrives.
    always_comb begin
        drop_next         = drop_q;
        kill_pending_next = kill_pending_reg;
        if (core_flush_i) begin
            drop_next         = outstanding_reg - CNT_W'(bus_rvalid_i) + CNT_W'(wait_hit);
            kill_pending_next = !is_idle && !bus_gnt_i;
        end else begin
            if (rsp_drop) begin
                drop_next = drop_next - CNT_W'(1);
            end
            if (wait_hit && kill_pending_reg) begin
                drop_next = drop_next + CNT_W'(1);
            end
            if (wait_hit) begin
                kill_pending_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg        <= IBUS_IDLE;
            addr_q           <= '0;
            outstanding_reg  <= '0;
            drop_q           <= '0;
            kill_pending_reg <= 1'b0;
        end else begin
            outstanding_reg  <= outstanding_next;
            drop_q           <= drop_next;
            kill_pending_reg <= kill_pending_next;
            unique case (state_reg)
                IBUS_IDLE: begin
                    if (issue && !bus_gnt_i) begin
                        addr_q    <= core_addr_i;
                        state_reg <= IBUS_WAIT_GNT;
                    end
                end
                IBUS_WAIT_GNT: begin
                    if (bus_gnt_i) begin
                        state_reg <= IBUS_IDLE;
                    end
                end
                default: state_reg <= IBUS_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_miriscv_ibus_bridge.sv
// Directed bench for miriscv_ibus_bridge with a simple in-order bus model
// (programmable grant enable and fixed response latency). Data returned = ~address.
module tb_miriscv_ibus_bridge;

    logic        clk;
    logic        rst;
    logic        core_req;
    logic [31:0] core_addr;
    logic        core_flush;
    logic        core_ready;
    logic        core_busy;
    logic        core_rvalid;
    logic [31:0] core_rdata;
    logic        core_err;
    logic        bus_req;
    logic [31:0] bus_addr;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;
    logic        bus_err;

    logic        gnt_en;
    int          lat;
    logic [31:0] err_addr;
    logic        pv [8];
    logic [31:0] pa [8];

    int checks;
    int errors;

`ifdef MIRISCV_IBUS_ERR_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    miriscv_ibus_bridge #(
        .DEPTH (2)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .core_req_i    (core_req),
        .core_addr_i   (core_addr),
        .core_flush_i  (core_flush),
        .core_ready_i  (core_ready),
        .core_busy_o   (core_busy),
        .core_rvalid_o (core_rvalid),
        .core_rdata_o  (core_rdata),
        .core_err_o    (core_err),
        .bus_req_o     (bus_req),
        .bus_addr_o    (bus_addr),
        .bus_gnt_i     (bus_gnt),
        .bus_rvalid_i  (bus_rvalid),
        .bus_rdata_i   (bus_rdata),
        .bus_err_i     (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bus model: a grant launches a response lat cycles later, in order.
    assign bus_gnt    = gnt_en;
    assign bus_rvalid = pv[0];
    assign bus_rdata  = ~pa[0];
    assign bus_err    = pv[0] && (pa[0] == err_addr);

    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 8; k++) begin
                pv[k] <= 1'b0;
                pa[k] <= 32'h0;
            end
        end else begin
            for (int k = 0; k < 7; k++) begin
                pv[k] <= pv[k+1];
                pa[k] <= pa[k+1];
            end
            pv[7] <= 1'b0;
            if (bus_req && bus_gnt) begin
                pv[lat-1] <= 1'b1;
                pa[lat-1] <= bus_addr;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        core_req   = 1'b1;
        core_addr  = 32'h0;
        core_flush = 1'b0;
        core_ready = 1'b1;
        gnt_en     = 1'b1;
        lat        = 1;
        err_addr   = 32'hFFFF_FFFF;

        // Reset: all outputs forced low even with a request pending.
        nxt();
        nxt();
        #1;
        $display("txn reset: bus_req=%0b busy=%0b rvalid=%0b", bus_req, core_busy, core_rvalid);
        chk("rst_bus_req", 32'(bus_req), 32'd0);
        chk("rst_busy", 32'(core_busy), 32'd0);
        chk("rst_rvalid", 32'(core_rvalid), 32'd0);
        chk("rst_rdata", core_rdata, 32'd0);
        chk("rst_err", 32'(core_err), 32'd0);
        nxt();
        rst      = 1'b0;
        core_req = 1'b0;

        // Zero-wait memory: 8 back-to-back fetches, one word per cycle.
        for (int i = 0; i < 10; i++) begin
            nxt();
            core_req  = (i < 8);
            core_addr = 32'h8000_0000 + 32'(4 * i);
            #1;
            $display("txn zw%0d: req=%0b addr=%h rvalid=%0b rdata=%h busy=%0b",
                     i, bus_req, bus_addr, core_rvalid, core_rdata, core_busy);
            chk("zw_busy", 32'(core_busy), 32'd0);
            chk("zw_bus_req", 32'(bus_req), 32'(i < 8));
            if (i < 8) chk("zw_bus_addr", bus_addr, 32'h8000_0000 + 32'(4 * i));
            chk("zw_rvalid", 32'(core_rvalid), 32'(i >= 1 && i <= 8));
            if (i >= 1 && i <= 8) chk("zw_rdata", core_rdata, ~(32'h8000_0000 + 32'(4 * (i - 1))));
            chk("zw_err", 32'(core_err), 32'd0);
        end

        // Grant delayed 3 cycles on 0x100.
        for (int k = 0; k < 4; k++) begin
            nxt();
            core_req  = 1'b1;
            core_addr = 32'h100;
            gnt_en    = (k == 3);
            #1;
            $display("txn gd%0d: req=%0b addr=%h busy=%0b", k, bus_req, bus_addr, core_busy);
            chk("gd_bus_req", 32'(bus_req), 32'd1);
            chk("gd_bus_addr", bus_addr, 32'h100);
            chk("gd_busy", 32'(core_busy), 32'd1);
            chk("gd_rvalid", 32'(core_rvalid), 32'd0);
        end
        nxt();
        core_req = 1'b0;
        gnt_en   = 1'b1;
        #1;
        $display("txn gd_data: rvalid=%0b rdata=%h", core_rvalid, core_rdata);
        chk("gd_data_rvalid", 32'(core_rvalid), 32'd1);
        chk("gd_data_rdata", core_rdata, ~32'h100);
        chk("gd_data_busy", 32'(core_busy), 32'd0);

        // Flush with a new fetch of 0x200 in the same cycle, latency 4.
        nxt();
        lat = 4;
        nxt();
        core_req  = 1'b1;
        core_addr = 32'h300;
        #1;
        chk("fl1_busy_a", 32'(core_busy), 32'd0);
        nxt();
        core_addr  = 32'h200;
        core_flush = 1'b1;
        #1;
        $display("txn fl1_issue: req=%0b addr=%h busy=%0b", bus_req, bus_addr, core_busy);
        chk("fl1_busy_new", 32'(core_busy), 32'd0);
        chk("fl1_bus_addr", bus_addr, 32'h200);
        nxt();
        core_req   = 1'b0;
        core_flush = 1'b0;
        #1;
        chk("fl1_drop_1", 32'(dut.drop_q), 32'd1);
        chk("fl1_outstanding", 32'(dut.outstanding_reg), 32'd2);
        nxt();
        #1;
        chk("fl1_rvalid_c3", 32'(core_rvalid), 32'd0);
        nxt();
        #1;
        chk("fl1_dropped", 32'(core_rvalid), 32'd0);
        nxt();
        #1;
        $display("txn fl1_data: rvalid=%0b rdata=%h drop=%0d", core_rvalid, core_rdata, dut.drop_q);
        chk("fl1_rvalid_new", 32'(core_rvalid), 32'd1);
        chk("fl1_rdata_new", core_rdata, ~32'h200);
        chk("fl1_drop_0", 32'(dut.drop_q), 32'd0);

        // Flush while waiting for a grant with one fetch already outstanding.
        nxt();
        core_req  = 1'b1;
        core_addr = 32'h400;
        #1;
        chk("fl2_busy_a", 32'(core_busy), 32'd0);
        nxt();
        core_addr = 32'h404;
        gnt_en    = 1'b0;
        #1;
        chk("fl2_busy_wait", 32'(core_busy), 32'd1);
        nxt();
        core_flush = 1'b1;
        #1;
        chk("fl2_req_held", 32'(bus_req), 32'd1);
        chk("fl2_addr_held", bus_addr, 32'h404);
        nxt();
        core_flush = 1'b0;
        gnt_en     = 1'b1;
        #1;
        chk("fl2_drop_1", 32'(dut.drop_q), 32'd1);
        chk("fl2_busy_gnt", 32'(core_busy), 32'd1);
        nxt();
        core_req = 1'b0;
        #1;
        $display("txn fl2: drop=%0d rvalid=%0b", dut.drop_q, core_rvalid);
        chk("fl2_drop_2", 32'(dut.drop_q), 32'd2);
        chk("fl2_dropped_a", 32'(core_rvalid), 32'd0);
        nxt();
        #1;
        chk("fl2_drop_1b", 32'(dut.drop_q), 32'd1);
        nxt();
        nxt();
        #1;
        chk("fl2_dropped_b", 32'(core_rvalid), 32'd0);
        nxt();
        core_req  = 1'b1;
        core_addr = 32'h208;
        #1;
        chk("fl2_drop_0", 32'(dut.drop_q), 32'd0);
        chk("fl2_busy_new", 32'(core_busy), 32'd0);
        for (int k = 0; k < 3; k++) begin
            nxt();
            core_req = 1'b0;
            #1;
            chk("fl2_wait_rvalid", 32'(core_rvalid), 32'd0);
        end
        nxt();
        #1;
        $display("txn fl2_data: rvalid=%0b rdata=%h", core_rvalid, core_rdata);
        chk("fl2_rvalid_new", 32'(core_rvalid), 32'd1);
        chk("fl2_rdata_new", core_rdata, ~32'h208);

        // Back-pressure: ready low for 3 cycles fills the buffer.
        nxt();
        lat = 1;
        nxt();
        core_req   = 1'b1;
        core_addr  = 32'h500;
        core_ready = 1'b0;
        #1;
        chk("bp_c0_busy", 32'(core_busy), 32'd0);
        nxt();
        core_addr = 32'h504;
        #1;
        chk("bp_c1_busy", 32'(core_busy), 32'd0);
        chk("bp_c1_rdata", core_rdata, ~32'h500);
        nxt();
        core_addr = 32'h508;
        #1;
        chk("bp_c2_bus_req", 32'(bus_req), 32'd0);
        chk("bp_c2_busy", 32'(core_busy), 32'd1);
        chk("bp_c2_rdata", core_rdata, ~32'h500);
        nxt();
        core_ready = 1'b1;
        #1;
        $display("txn bp_c3: count=%0d rvalid=%0b rdata=%h busy=%0b",
                 dut.rsp_count, core_rvalid, core_rdata, core_busy);
        chk("bp_c3_count", 32'(dut.rsp_count), 32'd2);
        chk("bp_c3_bus_req", 32'(bus_req), 32'd0);
        chk("bp_c3_busy", 32'(core_busy), 32'd1);
        chk("bp_c3_rdata", core_rdata, ~32'h500);
        nxt();
        #1;
        chk("bp_c4_rdata", core_rdata, ~32'h504);
        chk("bp_c4_bus_req", 32'(bus_req), 32'd1);
        chk("bp_c4_busy", 32'(core_busy), 32'd0);
        nxt();
        core_req = 1'b0;
        #1;
        $display("txn bp_c5: rvalid=%0b rdata=%h", core_rvalid, core_rdata);
        chk("bp_c5_rvalid", 32'(core_rvalid), 32'd1);
        chk("bp_c5_rdata", core_rdata, ~32'h508);

        // Error on the second response only.
        err_addr = 32'h604;
        nxt();
        core_req  = 1'b1;
        core_addr = 32'h600;
        nxt();
        core_addr = 32'h604;
        #1;
        chk("err_w1_rdata", core_rdata, ~32'h600);
        chk("err_w1_err", 32'(core_err), 32'd0);
        nxt();
        core_req = 1'b0;
        #1;
        $display("txn err_w2: rvalid=%0b rdata=%h err=%0b", core_rvalid, core_rdata, core_err);
        chk("err_w2_rdata", core_rdata, ~32'h604);
        chk("err_w2_err", 32'(core_err), 32'(ERR_EXP));
        nxt();
        #1;
        chk("err_after", 32'(core_err), 32'd0);

        // Reset while in WAIT_GNT with one fetch outstanding.
        lat = 4;
        nxt();
        core_req  = 1'b1;
        core_addr = 32'h700;
        nxt();
        core_addr = 32'h704;
        gnt_en    = 1'b0;
        #1;
        chk("rw_busy", 32'(core_busy), 32'd1);
        nxt();
        rst = 1'b1;
        #1;
        chk("rw_in_rst_req", 32'(bus_req), 32'd0);
        nxt();
        rst      = 1'b0;
        core_req = 1'b0;
        gnt_en   = 1'b1;
        #1;
        $display("txn rw: req=%0b rvalid=%0b state=%0d out=%0d drop=%0d",
                 bus_req, core_rvalid, dut.state_reg, dut.outstanding_reg, dut.drop_q);
        chk("rw_bus_req", 32'(bus_req), 32'd0);
        chk("rw_rvalid", 32'(core_rvalid), 32'd0);
        chk("rw_state", 32'(dut.state_reg), 32'd0);
        chk("rw_outstanding", 32'(dut.outstanding_reg), 32'd0);
        chk("rw_drop", 32'(dut.drop_q), 32'd0);
        chk("rw_count", 32'(dut.rsp_count), 32'd0);
        for (int k = 0; k < 5; k++) begin
            nxt();
            #1;
            chk("rw_quiet", 32'(core_rvalid), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
